// File: rtl/regfile_sb.sv
// regfile_sb: dual-read register file with an ALU write port, a byte-enabled
// load-return write port and a per-register busy scoreboard for loads in flight.
// Register 0 is hardwired to zero and can never be marked busy.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     reg1_pi,
    input  logic [ADDR_W-1:0]     reg2_pi,
    output logic [DATA_W-1:0]     operand1_po,
    output logic [DATA_W-1:0]     operand2_po,
    output logic                  busy1_po,
    output logic                  busy2_po,
    output logic                  stall_po,

    input  logic [ADDR_W-1:0]     destReg_pi,
    input  logic                  we_i,
    input  logic [DATA_W-1:0]     writeData_pi,

    input  logic [ADDR_W-1:0]     ldReg_pi,
    input  logic                  ld_we_i,
    input  logic [DATA_W/8-1:0]   ld_be_pi,
    input  logic [DATA_W-1:0]     ldData_pi,

    input  logic                  issue_i,
    input  logic [ADDR_W-1:0]     issueReg_pi,

    output logic [ADDR_W:0]       pending_cnt_po,
    output logic                  err_po
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int NUM_B    = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic                err_q;

    logic                a_wr;
    logic                b_wr;
    logic                ab_same;
    logic [DATA_W-1:0]   b_merged;

    logic                issue_set;
    logic                ld_clr;
    logic                set_clr_same;
    logic                cnt_inc;
    logic                cnt_dec;
    logic                waw_hit;

    // Replace only the enabled byte lanes of the old word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NUM_B-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < NUM_B; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Qualify write/issue requests; anything aimed at register 0 is dropped here.
    always_comb begin
        a_wr         = we_i && (destReg_pi != '0);
        b_wr         = ld_we_i && (ldReg_pi != '0);
        ab_same      = a_wr && b_wr && (destReg_pi == ldReg_pi);
        b_merged     = byte_merge(regs_q[ldReg_pi], ldData_pi, ld_be_pi);
        issue_set    = issue_i && (issueReg_pi != '0);
        ld_clr       = b_wr;
        set_clr_same = issue_set && ld_clr && (issueReg_pi == ldReg_pi);
    end

    // Register storage; port A is applied last so it overrides port B on a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (b_wr && !ab_same) begin
                regs_q[ldReg_pi] <= b_merged;
            end
            if (a_wr) begin
                regs_q[destReg_pi] <= writeData_pi;
            end
        end
    end

    // Next busy vector: load return clears, issue sets, and set wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (ld_clr) begin
            busy_d[ldReg_pi] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issueReg_pi] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending count tracks busy bit transitions, so it moves by at most one per cycle.
    always_comb begin
        cnt_inc = issue_set && !busy_q[issueReg_pi];
        cnt_dec = ld_clr && busy_q[ldReg_pi] && !set_clr_same;
        waw_hit = issue_set && busy_q[issueReg_pi] && !set_clr_same;
        cnt_d   = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Scoreboard state: busy bits, pending count and the sticky issue-over-busy error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (waw_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Read port 1: stored value, optionally forwarded from this cycle's writes.
    always_comb begin
        operand1_po = '0;
        if (reset && (reg1_pi != '0)) begin
            operand1_po = regs_q[reg1_pi];
            if (BYPASS != 0) begin
                if (a_wr && (destReg_pi == reg1_pi)) begin
                    operand1_po = writeData_pi;
                end else if (b_wr && (ldReg_pi == reg1_pi)) begin
                    operand1_po = b_merged;
                end
            end
        end
    end

    // Read port 2: same forwarding rules as port 1.
    always_comb begin
        operand2_po = '0;
        if (reset && (reg2_pi != '0)) begin
            operand2_po = regs_q[reg2_pi];
            if (BYPASS != 0) begin
                if (a_wr && (destReg_pi == reg2_pi)) begin
                    operand2_po = writeData_pi;
                end else if (b_wr && (ldReg_pi == reg2_pi)) begin
                    operand2_po = b_merged;
                end
            end
        end
    end

    // Busy outputs: a load returning this cycle already satisfies the reader when bypassing.
    always_comb begin
        busy1_po = reset && busy_q[reg1_pi];
        busy2_po = reset && busy_q[reg2_pi];
        if ((BYPASS != 0) && ld_we_i && (ldReg_pi == reg1_pi)) begin
            busy1_po = 1'b0;
        end
        if ((BYPASS != 0) && ld_we_i && (ldReg_pi == reg2_pi)) begin
            busy2_po = 1'b0;
        end
        stall_po       = busy1_po || busy2_po;
        pending_cnt_po = cnt_q;
        err_po         = err_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a bypassing and a non-bypassing regfile_sb with the same
// stimulus and compares both against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  reg1, reg2, dest, ld_reg, issue_reg;
    logic        we, ld_we, issue;
    logic [31:0] wdata, ld_data;
    logic [3:0]  ld_be;

    logic [31:0] op1_b, op2_b, op1_n, op2_n;
    logic        bz1_b, bz2_b, stall_b, err_b;
    logic        bz1_n, bz2_n, stall_n, err_n;
    logic [5:0]  cnt_b, cnt_n;

    int n_compared   = 0;
    int n_mismatched = 0;

    // reference model state
    logic [31:0] m_regs  [32];
    logic [31:0] nx_regs [32];
    logic [31:0] m_busy, nx_busy;
    logic        m_err, nx_err;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .reg1_pi(reg1), .reg2_pi(reg2),
        .operand1_po(op1_b), .operand2_po(op2_b),
        .busy1_po(bz1_b), .busy2_po(bz2_b), .stall_po(stall_b),
        .destReg_pi(dest), .we_i(we), .writeData_pi(wdata),
        .ldReg_pi(ld_reg), .ld_we_i(ld_we), .ld_be_pi(ld_be), .ldData_pi(ld_data),
        .issue_i(issue), .issueReg_pi(issue_reg),
        .pending_cnt_po(cnt_b), .err_po(err_b)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset),
        .reg1_pi(reg1), .reg2_pi(reg2),
        .operand1_po(op1_n), .operand2_po(op2_n),
        .busy1_po(bz1_n), .busy2_po(bz2_n), .stall_po(stall_n),
        .destReg_pi(dest), .we_i(we), .writeData_pi(wdata),
        .ldReg_pi(ld_reg), .ld_we_i(ld_we), .ld_be_pi(ld_be), .ldData_pi(ld_data),
        .issue_i(issue), .issueReg_pi(issue_reg),
        .pending_cnt_po(cnt_n), .err_po(err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic clear_inputs();
        reg1 = 0; reg2 = 0; dest = 0; ld_reg = 0; issue_reg = 0;
        we = 0; ld_we = 0; issue = 0; wdata = 0; ld_data = 0; ld_be = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_busy = 0;
        m_err  = 0;
    endtask

    // Post-edge state computed straight from the write/scoreboard rules.
    task automatic model_next();
        nx_regs = m_regs;
        if (ld_we && ld_reg != 0)
            for (int b = 0; b < 4; b++)
                if (ld_be[b]) nx_regs[ld_reg][b*8 +: 8] = ld_data[b*8 +: 8];
        if (we && dest != 0) nx_regs[dest] = wdata;
        nx_busy = m_busy;
        nx_err  = m_err;
        if (ld_we) nx_busy[ld_reg] = 1'b0;
        if (issue && issue_reg != 0) begin
            if (m_busy[issue_reg] && !(ld_we && ld_reg == issue_reg)) nx_err = 1'b1;
            nx_busy[issue_reg] = 1'b1;
        end
        nx_busy[0] = 1'b0;
    endtask

    task automatic check_reads();
        logic e1b, e2b;
        e1b = m_busy[reg1] && !(ld_we && ld_reg == reg1);
        e2b = m_busy[reg2] && !(ld_we && ld_reg == reg2);
        check_val("op1_byp", op1_b, nx_regs[reg1]);
        check_val("op2_byp", op2_b, nx_regs[reg2]);
        check_val("op1_nob", op1_n, m_regs[reg1]);
        check_val("op2_nob", op2_n, m_regs[reg2]);
        check_val("bz1_byp", bz1_b, e1b);
        check_val("bz2_byp", bz2_b, e2b);
        check_val("bz1_nob", bz1_n, m_busy[reg1]);
        check_val("bz2_nob", bz2_n, m_busy[reg2]);
        check_val("stall_byp", stall_b, e1b || e2b);
        check_val("stall_nob", stall_n, m_busy[reg1] || m_busy[reg2]);
    endtask

    task automatic check_state();
        check_val("cnt_byp", cnt_b, popc(m_busy));
        check_val("cnt_nob", cnt_n, popc(m_busy));
        check_val("err_byp", err_b, m_err);
        check_val("err_nob", err_n, m_err);
    endtask

    // Evaluate the current inputs, cross one rising edge, then check registered state.
    task automatic step_here();
        #1;
        model_next();
        check_reads();
        @(posedge clk);
        m_regs = nx_regs;
        m_busy = nx_busy;
        m_err  = nx_err;
        #1;
        check_state();
    endtask

    task automatic step();
        @(negedge clk);
        step_here();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_op1b"}, op1_b, 0);
        check_val({tag, "_op2b"}, op2_b, 0);
        check_val({tag, "_op1n"}, op1_n, 0);
        check_val({tag, "_bz1b"}, bz1_b, 0);
        check_val({tag, "_bz2b"}, bz2_b, 0);
        check_val({tag, "_stallb"}, stall_b, 0);
        check_val({tag, "_stalln"}, stall_n, 0);
        check_val({tag, "_cntb"}, cnt_b, 0);
        check_val({tag, "_cntn"}, cnt_n, 0);
        check_val({tag, "_errb"}, err_b, 0);
        check_val({tag, "_errn"}, err_n, 0);
    endtask

    // Pull reset low between edges with live inputs, check outputs, release near a negedge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk);
        clear_inputs();
        #2 reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b0;
        #3 check_all_zero("rst_init");
        #9 reset = 1'b1;                     // t=12, between edges
        step_here();

        // register 0 ignores writes and issues
        we = 1; dest = 0; wdata = 32'hFFFF_FFFF; issue = 1; issue_reg = 0; reg1 = 0; reg2 = 0;
        #2 check_val("x0_op1", op1_b, 0);
        step();
        check_val("x0_cnt", cnt_b, 0);
        clear_inputs();
        #2 check_val("x0_busy", bz1_b, 0);
        step();

        // port A write with same-cycle read
        we = 1; dest = 5; wdata = 32'hDEAD_BEEF; reg1 = 5;
        #2 check_val("fwd_a_byp", op1_b, 32'hDEAD_BEEF);
        check_val("fwd_a_nob", op1_n, 0);
        step();
        clear_inputs(); reg1 = 5;
        #2 check_val("stored_a_nob", op1_n, 32'hDEAD_BEEF);
        step();

        // byte-enabled load return
        we = 1; dest = 7; wdata = 32'h1122_3344;
        step();
        clear_inputs();
        ld_we = 1; ld_reg = 7; ld_be = 4'b0101; ld_data = 32'hAABB_CCDD; reg2 = 7;
        #2 check_val("fwd_b_byp", op2_b, 32'h11BB_33DD);
        check_val("fwd_b_nob", op2_n, 32'h1122_3344);
        step();
        clear_inputs(); reg2 = 7;
        #2 check_val("merge_b_nob", op2_n, 32'h11BB_33DD);
        step();

        // A/B collision: A data wins, busy still clears
        clear_inputs(); issue = 1; issue_reg = 9;
        step();
        clear_inputs();
        we = 1; dest = 9; wdata = 32'h1; ld_we = 1; ld_reg = 9; ld_be = 4'hF; ld_data = 32'h2; reg1 = 9;
        #2 check_val("coll_byp", op1_b, 32'h1);
        step();
        clear_inputs(); reg1 = 9;
        #2 check_val("coll_nob", op1_n, 32'h1);
        check_val("coll_busy", bz1_n, 0);
        step();

        // issue, re-issue error, issue+return on the same register
        clear_inputs(); issue = 1; issue_reg = 3; reg1 = 3;
        step();
        clear_inputs(); reg1 = 3;
        #2 check_val("iss_bz1", bz1_b, 1);
        check_val("iss_stall", stall_b, 1);
        check_val("iss_cnt", cnt_b, 1);
        issue = 1; issue_reg = 3;
        step();
        check_val("waw_err", err_b, 1);
        clear_inputs(); issue = 1; issue_reg = 3; ld_we = 1; ld_reg = 3; ld_be = 4'h0;
        step();
        check_val("setwin_cnt", cnt_b, 1);
        clear_inputs(); reg1 = 3;
        #2 check_val("setwin_bz", bz1_n, 1);
        step();

        // issue x1,x2,x4 then async reset mid-cycle with writes in flight
        clear_inputs(); issue = 1; issue_reg = 1; step();
        issue_reg = 2; step();
        issue_reg = 4; step();
        clear_inputs(); we = 1; dest = 1; wdata = 32'h55; reg1 = 1; reg2 = 2; issue = 1; issue_reg = 6;
        async_reset("rst_mid");
        reg1 = 1;
        step_here();
        check_val("rst_x1", op1_n, 0);
        check_val("rst_cnt", cnt_b, 0);

        // randomized traffic with periodic asynchronous resets
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) begin
                we = 1; dest = 5'($urandom_range(1, 31)); reg1 = dest; wdata = $urandom;
                async_reset("rst_rnd");
                step_here();
            end else begin
                we        = ($urandom_range(0, 1) == 1);
                ld_we     = ($urandom_range(0, 9) < 4);
                issue     = ($urandom_range(0, 9) < 3);
                dest      = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
                ld_reg    = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
                issue_reg = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
                wdata     = $urandom;
                ld_data   = $urandom;
                ld_be     = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       reg1 = dest;
                    1:       reg1 = ld_reg;
                    default: reg1 = 5'($urandom_range(0, 7));
                endcase
                reg2 = ($urandom_range(0, 1) == 1) ? ld_reg : 5'($urandom_range(0, 31));
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
